// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder sequencer: FSM states and
// hold-counter width.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    localparam int CNT_W      = 8;
    localparam int CODE_W     = 3;
    localparam int NUM_OUTS   = 8;
    localparam logic [CODE_W-1:0] LAST_CODE = 3'd7;

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder; exactly one output bit is set for
// every input code.
module dec3to8
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [NUM_OUTS-1:0] onehot
);

    // NOTE: assign a default before the indexed write so every path drives
    // every bit; otherwise the synthesizer infers latches.
    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/decoder_seq.sv
// Decoder sequencer: holds a one-hot decode of an accepted code for
// HOLD_CYCLES cycles, or sweeps codes 0..7 and pulses done at the end.
module decoder_seq
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic valid,
    output logic ready,
    input  logic sweep_start,
    output logic D0,
    output logic D1,
    output logic D2,
    output logic D3,
    output logic D4,
    output logic D5,
    output logic D6,
    output logic D7,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CODE_W-1:0]    code;
    logic [NUM_OUTS-1:0]  d_q;
    logic [CODE_W-1:0]    dec_in;
    logic [NUM_OUTS-1:0]  dec_out;

    // Code presented to the decoder: the one about to be loaded into d_q.
    always_comb begin
        dec_in = code;
        case (state)
            IDLE:    dec_in = sweep_start ? '0 : {A2, A1, A0};
            SWEEP:   dec_in = code + 3'd1;
            default: dec_in = code;
        endcase
    end

    dec3to8 u_dec (
        .code   (dec_in),
        .onehot (dec_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= '0;
            d_q   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sweep_start || valid) begin
                        state <= sweep_start ? SWEEP : HOLD;
                        code  <= dec_in;
                        cnt   <= HOLD_LOAD;
                        d_q   <= dec_out;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        d_q   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SWEEP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (code == LAST_CODE) begin
                        state <= IDLE;
                        d_q   <= '0;
                        done  <= 1'b1;
                    end else begin
                        code <= dec_in;
                        cnt  <= HOLD_LOAD;
                        d_q  <= dec_out;
                    end
                end
                default: begin
                    state <= IDLE;
                    d_q   <= '0;
                end
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);
    assign {D7, D6, D5, D4, D3, D2, D1, D0} = d_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench: three decoder_seq instances (HOLD_CYCLES 4, 2, 1) on
// shared stimulus, checked every cycle against a timeline-based model.
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] a = 3'd0;
    logic       valid = 1'b0;
    logic       sweep_start = 1'b0;

    logic [7:0] d_out   [3];
    logic       ready_o [3];
    logic       busy_o  [3];
    logic       done_o  [3];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        decoder_seq #(.HOLD_CYCLES(k == 0 ? 4 : (k == 1 ? 2 : 1))) u_dut (
            .clk         (clk),
            .rst         (rst),
            .A0          (a[0]),
            .A1          (a[1]),
            .A2          (a[2]),
            .valid       (valid),
            .ready       (ready_o[k]),
            .sweep_start (sweep_start),
            .D0          (d_out[k][0]),
            .D1          (d_out[k][1]),
            .D2          (d_out[k][2]),
            .D3          (d_out[k][3]),
            .D4          (d_out[k][4]),
            .D5          (d_out[k][5]),
            .D6          (d_out[k][6]),
            .D7          (d_out[k][7]),
            .busy        (busy_o[k]),
            .done        (done_o[k])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each instance remembers its last operation (0 none, 1 hold,
    // 2 sweep), its code, and the edge number that started it. Outputs are
    // derived purely from elapsed cycles since that edge.
    int cyc = 0;
    int kind    [3] = '{0, 0, 0};
    int code_m  [3] = '{0, 0, 0};
    int start_m [3] = '{0, 0, 0};

    function automatic int hval(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
    endfunction

    function automatic bit m_busy(input int k, input int n);
        int e = n - start_m[k];
        return (kind[k] == 1 && e < hval(k)) || (kind[k] == 2 && e < 8 * hval(k));
    endfunction

    function automatic logic [7:0] m_d(input int k, input int n);
        int e = n - start_m[k];
        logic [7:0] one = 8'd1;
        if (kind[k] == 1 && e < hval(k)) return one << code_m[k];
        if (kind[k] == 2 && e < 8 * hval(k)) return one << (e / hval(k));
        return 8'd0;
    endfunction

    function automatic bit m_done(input int k, input int n);
        return kind[k] == 2 && (n - start_m[k]) == 8 * hval(k);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                kind[k] <= 0;
            end else if (!m_busy(k, cyc)) begin
                if (sweep_start) begin
                    kind[k]    <= 2;
                    start_m[k] <= cyc + 1;
                end else if (valid) begin
                    kind[k]    <= 1;
                    code_m[k]  <= int'(a);
                    start_m[k] <= cyc + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("cmp_h%0d", hval(k)),
                      {21'b0, d_out[k], ready_o[k], busy_o[k], done_o[k]},
                      {21'b0, m_d(k, cyc), !m_busy(k, cyc), m_busy(k, cyc), m_done(k, cyc)});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(ready_o[0] && ready_o[1] && ready_o[2]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", {31'b0, n >= 200}, 32'd0);
    endtask

    initial begin
        logic [7:0] one = 8'd1;

        // Reset for two cycles, then release.
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_d", {24'b0, d_out[0]}, 32'h0);
        check("rst_ready", {29'b0, ready_o[0], ready_o[1], ready_o[2]}, 32'h7);
        check("rst_busy_done", {30'b0, busy_o[0], done_o[0]}, 32'h0);
        @(negedge clk);
        check("ready_after_rst", {31'b0, ready_o[0]}, 32'h1);

        // Single code 5 on H=4.
        a = 3'd5; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) valid = 1'b0;
            check("hold5_d", {24'b0, d_out[0]}, 32'h20);
            check("hold5_ready", {31'b0, ready_o[0]}, 32'h0);
        end
        @(negedge clk);
        check("hold5_end", {23'b0, d_out[0], ready_o[0]}, 32'h1);
        wait_idle();

        // valid held: code 3 then 6 during HOLD.
        a = 3'd3; valid = 1'b1;
        @(negedge clk);
        a = 3'd6;
        check("hold3_d", {24'b0, d_out[0]}, 32'h08);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("hold3_d", {24'b0, d_out[0]}, 32'h08);
        end
        @(negedge clk);
        check("hold3_gap", {23'b0, d_out[0], ready_o[0]}, 32'h1);
        @(negedge clk);
        valid = 1'b0;
        check("hold6_d", {24'b0, d_out[0]}, 32'h40);
        wait_idle();

        // Full sweep on H=2.
        sweep_start = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i == 0) sweep_start = 1'b0;
            if (i < 16)
                check("sweep_d", {23'b0, d_out[1], done_o[1]}, {23'b0, one << (i / 2), 1'b0});
            else
                check("sweep_done", {23'b0, d_out[1], done_o[1], ready_o[1]}, 32'h3);
        end
        @(negedge clk);
        check("sweep_done_pulse", {31'b0, done_o[1]}, 32'h0);
        wait_idle();

        // sweep_start wins over simultaneous valid with code 2.
        a = 3'd2; valid = 1'b1; sweep_start = 1'b1;
        @(negedge clk);
        valid = 1'b0; sweep_start = 1'b0;
        check("prio_d", {8'b0, d_out[0], d_out[1], d_out[2]}, 32'h010101);
        wait_idle();

        // Reset during the D4 step of a sweep on H=2.
        sweep_start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) sweep_start = 1'b0;
        end
        check("abort_d4", {24'b0, d_out[1]}, 32'h10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_d", {8'b0, d_out[0], d_out[1], d_out[2]}, 32'h0);
        check("abort_done", {29'b0, done_o[0], done_o[1], done_o[2]}, 32'h0);
        @(negedge clk);
        check("abort_ready", {29'b0, ready_o[0], ready_o[1], ready_o[2]}, 32'h7);

        // Back-to-back accepts on H=1 every two cycles.
        a = 3'd7; valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("h1_b2b", {24'b0, d_out[2]}, (i % 2 == 0) ? 32'h80 : 32'h0);
        end
        valid = 1'b0;
        wait_idle();

        // Randomized traffic, checked by the per-cycle compare process.
        for (int i = 0; i < 600; i++) begin
            a           = 3'($urandom_range(0, 7));
            valid       = ($urandom_range(0, 1) == 1);
            sweep_start = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        rst = 1'b0; valid = 1'b0; sweep_start = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
